systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 4: PE array dimension, 2..16.
REQ-002 Parameter CW, default 8: width of vector counter and num_vec.
REQ-003 Derived constant L = 2N-1: array fill/drain latency in issued beats.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  job request, sampled in IDLE only.
REQ-008 reuse_w  in  1  sampled with start; 1 = skip weight load.
REQ-009 num_vec  in  CW  activation vectors per job, sampled with start.
REQ-010 abort  in  1  synchronous job cancel.
REQ-011 w_valid / w_ready  in / out  1  weight-row stream handshake.
REQ-012 a_valid / a_ready  in / out  1  activation-vector stream handshake.
REQ-013 pe_valid  out  1  array-wide advance enable driven to every PE valid input.
REQ-014 pe_conf  out  1  array-wide weight-configure select driven to every PE conf input.
REQ-015 feed_zero  out  1  north-edge feed mux forces zero data.
REQ-016 res_valid  out  1  east-edge result column carries a real result this cycle.
REQ-017 busy  out  1  job in progress; done  out  1  one-cycle job-complete pulse.

Function
REQ-018 States SHALL be IDLE, LOAD, COMPUTE, DRAIN, DONE.
REQ-019 IDLE: start=1 with num_vec!=0 latches num_vec and reuse_w; next = COMPUTE if reuse_w else LOAD; start with num_vec=0 is ignored.
REQ-020 LOAD: w_ready=1; each cycle with w_valid=1 is a beat with pe_valid=1, pe_conf=1; after exactly N beats, next = COMPUTE.
REQ-021 LOAD rows SHALL be accepted bottom-row-first, since weights shift south one row per beat.
REQ-022 COMPUTE: a_ready=1; each cycle with a_valid=1 is a beat with pe_valid=1, pe_conf=0; after num_vec beats, next = DRAIN.
REQ-023 DRAIN: exactly L consecutive cycles with pe_valid=1, pe_conf=0, feed_zero=1; then DONE.
REQ-024 DONE: done=1 for one cycle; next = IDLE.
REQ-025 In LOAD/COMPUTE, w_valid/a_valid low SHALL give pe_valid=0 (array holds state); no timeout.
REQ-026 w_ready and a_ready SHALL be 0 outside LOAD and COMPUTE respectively; w_valid/a_valid in other states SHALL be ignored.
REQ-027 busy SHALL be 1 in LOAD, COMPUTE, DRAIN, DONE; start while busy SHALL be ignored.
REQ-028 A tag pipe of L bits SHALL shift only on pe_valid=1 cycles; it SHALL enter 1 on COMPUTE beats and 0 on LOAD/DRAIN beats.
REQ-029 res_valid SHALL equal pe_valid AND the tag shifted in L beats earlier (tag_pipe[L-1]), combinationally.
REQ-030 Exactly num_vec res_valid cycles SHALL occur per job; the last SHALL coincide with the final DRAIN cycle.
REQ-031 Vector counter SHALL count 0..num_vec-1 and SHALL NOT wrap; num_vec = 2^CW-1 is legal.
REQ-032 abort=1 in any non-IDLE state: next = IDLE, tag pipe cleared, no done pulse; abort has priority over beats the same cycle.
REQ-033 A cycle with abort=1 SHALL drive pe_valid=0, w_ready=0, a_ready=0.
REQ-034 abort in IDLE has no effect; abort and start in the same IDLE cycle: start is ignored.

Reset
REQ-035 rst=1 SHALL immediately force IDLE and clear the counters and tag pipe, regardless of clk.
REQ-036 During and after reset, until the next job: pe_valid, pe_conf, feed_zero, res_valid, busy, done, w_ready, a_ready = 0.
REQ-037 Reset mid-job SHALL discard the job with no done pulse; latched num_vec/reuse_w are don't-care.

Verification
REQ-038 N=4, start, reuse_w=0, num_vec=3, valids always 1 -> 4 LOAD beats, 3 COMPUTE beats, 7 DRAIN cycles, done in cycle 15 after start; res_valid high in the last 3 DRAIN cycles.
REQ-039 N=4, reuse_w=1, num_vec=1 -> no w_ready; 1 COMPUTE beat, 7 DRAIN cycles; res_valid only in the 7th DRAIN cycle.
REQ-040 a_valid toggling 1,0,1,0 during COMPUTE, num_vec=2 -> pe_valid mirrors a_valid; tag pipe frozen on 0 cycles; exactly 2 res_valid.
REQ-041 abort on the 2nd DRAIN cycle -> IDLE next cycle, no done, res_valid 0; a following job behaves as in REQ-038.
REQ-042 rst asserted mid-COMPUTE between clock edges -> all outputs 0 before the next edge; start with num_vec=0 afterwards -> stays IDLE.
REQ-043 start held high through an entire job -> exactly one job runs, then a new job starts on the IDLE cycle after done.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// Purpose: handshake/control bundle between a job source, the systolic array and systolic_ctrl.
// Latency: n/a (signal bundle only).
// Backpressure: w_ready/a_ready flow from the controller back to the weight and activation streams.
// Ports: start/reuse_w/num_vec/abort (job control), w_valid/w_ready, a_valid/a_ready (streams),
//        pe_valid/pe_conf/feed_zero/res_valid (array controls), busy/done (status).
interface systolic_ctrl_if #(
  parameter int CW = 8
);
  logic          start;
  logic          reuse_w;
  logic [CW-1:0] num_vec;
  logic          abort;
  logic          w_valid;
  logic          w_ready;
  logic          a_valid;
  logic          a_ready;
  logic          pe_valid;
  logic          pe_conf;
  logic          feed_zero;
  logic          res_valid;
  logic          busy;
  logic          done;

  // Job source / stream producer side
  modport master (
    output start, reuse_w, num_vec, abort, w_valid, a_valid,
    input  w_ready, a_ready, pe_valid, pe_conf, feed_zero, res_valid, busy, done
  );

  // Controller side
  modport slave (
    input  start, reuse_w, num_vec, abort, w_valid, a_valid,
    output w_ready, a_ready, pe_valid, pe_conf, feed_zero, res_valid, busy, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Purpose: sequences an NxN weight-stationary systolic array through weight load, compute and drain.
// Latency: results appear L=2N-1 array beats after their activation beat; done 1 cycle after drain.
// Backpressure: LOAD/COMPUTE advance only on w_valid/a_valid beats (array freezes otherwise); DRAIN never stalls.
// Ports: clk, rst (async, active-high); bus (systolic_ctrl_if.slave) carrying job control,
//        weight/activation handshakes, array-wide PE controls and busy/done status.
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.slave bus
);

  localparam int L    = 2 * N - 1;
  // Counter must hold both num_vec-1 and L-1.
  localparam int CNTW = (CW > $clog2(2 * N)) ? CW : $clog2(2 * N);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] N_M1    = CNTW'(N - 1);
  localparam logic [CNTW-1:0] L_M1    = CNTW'(L - 1);
  localparam logic [CW-1:0]   NV_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [CW-1:0]   r_num_vec;
  logic [L-1:0]    r_tag;
  logic            r_pe_conf;
  logic            r_feed_zero;
  logic            r_busy;
  logic            r_done;

  logic            w_load_beat;
  logic            w_comp_beat;
  logic            w_drain_beat;
  logic            w_pe_valid;
  logic            w_last_vec;
  logic [CNTW-1:0] w_nv_m1;

  // Abort wins over any beat in the same cycle: the array must not advance.
  assign w_load_beat  = (r_state == S_LOAD)    && bus.w_valid && !bus.abort;
  assign w_comp_beat  = (r_state == S_COMPUTE) && bus.a_valid && !bus.abort;
  assign w_drain_beat = (r_state == S_DRAIN)   && !bus.abort;
  assign w_pe_valid   = w_load_beat | w_comp_beat | w_drain_beat;

  // num_vec is nonzero whenever a job is running, so the subtraction cannot underflow.
  assign w_nv_m1    = CNTW'(r_num_vec - NV_ONE);
  assign w_last_vec = (r_cnt == w_nv_m1);

  assign bus.w_ready   = (r_state == S_LOAD)    && !bus.abort;
  assign bus.a_ready   = (r_state == S_COMPUTE) && !bus.abort;
  assign bus.pe_valid  = w_pe_valid;
  // The tag leaving the pipe marks a beat whose column output is a real result.
  assign bus.res_valid = w_pe_valid & r_tag[L-1];
  assign bus.pe_conf   = r_pe_conf;
  assign bus.feed_zero = r_feed_zero;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_num_vec   <= '0;
      r_tag       <= '0;
      r_pe_conf   <= 1'b0;
      r_feed_zero <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (bus.abort && (r_state != S_IDLE)) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tag       <= '0;
      r_pe_conf   <= 1'b0;
      r_feed_zero <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Tag pipe tracks the array's own advance: it moves only when the PEs do.
      if (w_pe_valid) begin
        r_tag <= {r_tag[L-2:0], w_comp_beat};
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start && (bus.num_vec != '0) && !bus.abort) begin
            r_num_vec <= bus.num_vec;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            // reuse_w only steers this transition, so it is not held afterwards.
            if (bus.reuse_w) begin
              r_state <= S_COMPUTE;
            end else begin
              r_state   <= S_LOAD;
              r_pe_conf <= 1'b1;
            end
          end
        end

        // Rows arrive bottom-row-first; each beat shifts the weights one row south.
        S_LOAD: begin
          if (w_load_beat) begin
            if (r_cnt == N_M1) begin
              r_cnt     <= '0;
              r_state   <= S_COMPUTE;
              r_pe_conf <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end

        S_COMPUTE: begin
          if (w_comp_beat) begin
            if (w_last_vec) begin
              r_cnt       <= '0;
              r_state     <= S_DRAIN;
              r_feed_zero <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end

        S_DRAIN: begin
          if (r_cnt == L_M1) begin
            r_cnt       <= '0;
            r_state     <= S_DONE;
            r_feed_zero <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_pe_conf   <= 1'b0;
          r_feed_zero <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Purpose: self-checking bench for systolic_ctrl (N=4, CW=8) using per-cycle vector tables plus corner sequences.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: stalls are exercised by dropping w_valid/a_valid in the vector tables.
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int CW = 8;

  // Expected output vectors: {pe_valid, pe_conf, feed_zero, res_valid, busy, done, w_ready, a_ready}
  localparam logic [7:0] IDL = 8'b0000_0000;
  localparam logic [7:0] LD  = 8'b1100_1010;
  localparam logic [7:0] LDW = 8'b0100_1010;
  localparam logic [7:0] CP  = 8'b1000_1001;
  localparam logic [7:0] CPW = 8'b0000_1001;
  localparam logic [7:0] DR  = 8'b1010_1000;
  localparam logic [7:0] DRV = 8'b1011_1000;
  localparam logic [7:0] DN  = 8'b0000_1100;
  localparam logic [7:0] ABD = 8'b0010_1000;

  typedef struct {
    string         name;
    logic          start;
    logic          reuse_w;
    logic          abort;
    logic          w_valid;
    logic          a_valid;
    logic [CW-1:0] num_vec;
    logic [7:0]    exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  systolic_ctrl_if #(.CW(CW)) bus ();

  systolic_ctrl #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] outs();
    return {bus.pe_valid, bus.pe_conf, bus.feed_zero, bus.res_valid,
            bus.busy, bus.done, bus.w_ready, bus.a_ready};
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic st, input logic ru, input logic ab,
                     input logic wv, input logic av, input int nv, input logic [7:0] exp,
                     input int reps);
    vec_t v;
    v.name = nm; v.start = st; v.reuse_w = ru; v.abort = ab;
    v.w_valid = wv; v.a_valid = av; v.num_vec = CW'(nv); v.exp = exp;
    for (int r = 0; r < reps; r++) tbl.push_back(v);
  endtask

  task automatic drive(input logic st, input logic ru, input logic ab,
                       input logic wv, input logic av, input logic [CW-1:0] nv);
    bus.start = st; bus.reuse_w = ru; bus.abort = ab;
    bus.w_valid = wv; bus.a_valid = av; bus.num_vec = nv;
  endtask

  // Full job: load 4 rows, 3 vectors, 7 drain cycles, done 15 cycles after start.
  task automatic add_job_full(input string nm);
    add(nm, 1, 0, 0, 1, 1, 3, IDL, 1);
    add(nm, 0, 0, 0, 1, 1, 0, LD,  4);
    add(nm, 0, 0, 0, 1, 1, 0, CP,  3);
    add(nm, 0, 0, 0, 1, 1, 0, DR,  4);
    add(nm, 0, 0, 0, 1, 1, 0, DRV, 3);
    add(nm, 0, 0, 0, 1, 1, 0, DN,  1);
    add(nm, 0, 0, 0, 1, 1, 0, IDL, 1);
  endtask

  initial begin
    int rv_cnt;
    int last_rv;
    int done_at;

    drive(0, 0, 0, 0, 0, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 0, 32'(outs()), 32'(IDL));
    @(negedge clk);
    rst = 1'b0;

    add_job_full("job_full");

    // Weights reused, single vector: only the last drain cycle carries a result.
    add("reuse_1vec", 1, 1, 0, 1, 1, 1, IDL, 1);
    add("reuse_1vec", 0, 0, 0, 1, 1, 0, CP,  1);
    add("reuse_1vec", 0, 0, 0, 1, 1, 0, DR,  6);
    add("reuse_1vec", 0, 0, 0, 1, 1, 0, DRV, 1);
    add("reuse_1vec", 0, 0, 0, 1, 1, 0, DN,  1);
    add("reuse_1vec", 0, 0, 0, 1, 1, 0, IDL, 1);

    // a_valid toggling 1,0,1,0: array holds on the gap, tag pipe frozen.
    add("a_toggle", 1, 1, 0, 0, 1, 2, IDL, 1);
    add("a_toggle", 0, 0, 0, 0, 1, 0, CP,  1);
    add("a_toggle", 0, 0, 0, 0, 0, 0, CPW, 1);
    add("a_toggle", 0, 0, 0, 0, 1, 0, CP,  1);
    add("a_toggle", 0, 0, 0, 0, 0, 0, DR,  5);
    add("a_toggle", 0, 0, 0, 0, 0, 0, DRV, 2);
    add("a_toggle", 0, 0, 0, 0, 0, 0, DN,  1);
    add("a_toggle", 0, 0, 0, 0, 0, 0, IDL, 1);

    // Abort on the 2nd drain cycle, then start+abort together and start with num_vec=0.
    add("abort_drain", 1, 1, 0, 0, 1, 3, IDL, 1);
    add("abort_drain", 0, 0, 0, 0, 1, 0, CP,  3);
    add("abort_drain", 0, 0, 0, 0, 1, 0, DR,  1);
    add("abort_drain", 0, 0, 1, 0, 1, 0, ABD, 1);
    add("abort_drain", 0, 0, 0, 0, 1, 0, IDL, 1);
    add("start_abort", 1, 0, 1, 1, 1, 3, IDL, 1);
    add("start_abort", 0, 0, 0, 1, 1, 0, IDL, 1);
    add("start_nv0",   1, 0, 0, 1, 1, 0, IDL, 1);
    add("start_nv0",   0, 0, 0, 1, 1, 0, IDL, 1);
    add_job_full("job_after_abort");

    // Stalled load and compute; stray valids on the other stream are ignored.
    add("stalls", 1, 0, 0, 0, 0, 1, IDL, 1);
    add("stalls", 0, 0, 0, 1, 0, 0, LD,  1);
    add("stalls", 0, 0, 0, 0, 1, 0, LDW, 1);
    add("stalls", 0, 0, 0, 1, 0, 0, LD,  3);
    add("stalls", 0, 0, 0, 1, 0, 0, CPW, 1);
    add("stalls", 0, 0, 0, 1, 1, 0, CP,  1);
    add("stalls", 0, 0, 0, 1, 1, 0, DR,  6);
    add("stalls", 0, 0, 0, 1, 1, 0, DRV, 1);
    add("stalls", 0, 0, 0, 1, 1, 0, DN,  1);
    add("stalls", 0, 0, 0, 1, 1, 0, IDL, 1);

    // start held through a whole job: next job begins on the IDLE cycle after done.
    add("start_held", 1, 1, 0, 0, 1, 1, IDL, 1);
    add("start_held", 1, 1, 0, 0, 1, 1, CP,  1);
    add("start_held", 1, 1, 0, 0, 1, 1, DR,  6);
    add("start_held", 1, 1, 0, 0, 1, 1, DRV, 1);
    add("start_held", 1, 1, 0, 0, 1, 1, DN,  1);
    add("start_held", 1, 1, 0, 0, 1, 1, IDL, 1);
    add("start_held", 1, 1, 0, 0, 1, 1, CP,  1);
    add("start_held", 0, 0, 0, 0, 1, 0, DR,  6);
    add("start_held", 0, 0, 0, 0, 1, 0, DRV, 1);
    add("start_held", 0, 0, 0, 0, 1, 0, DN,  1);
    add("start_held", 0, 0, 0, 0, 1, 0, IDL, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].start, tbl[i].reuse_w, tbl[i].abort, tbl[i].w_valid, tbl[i].a_valid, tbl[i].num_vec);
      #1 check(tbl[i].name, i, 32'(outs()), 32'(tbl[i].exp));
    end

    // Asynchronous reset between clock edges in the middle of COMPUTE.
    @(negedge clk);
    drive(1, 1, 0, 0, 1, CW'(5));
    @(negedge clk);
    drive(0, 0, 0, 0, 1, '0);
    @(negedge clk);
    #1 check("mid_compute", 0, 32'(outs()), 32'(CP));
    #1 rst = 1'b1;
    #1 check("async_reset", 0, 32'(outs()), 32'(IDL));
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 1, 1, '0);
    @(negedge clk);
    drive(0, 0, 0, 1, 1, '0);
    #1 check("post_rst_nv0", 0, 32'(outs()), 32'(IDL));
    @(negedge clk);
    #1 check("post_rst_nv0", 1, 32'(outs()), 32'(IDL));

    // Largest num_vec: counter must not wrap, exactly 255 results, last one right before done.
    @(negedge clk);
    drive(1, 1, 0, 0, 1, CW'(255));
    @(negedge clk);
    drive(0, 0, 0, 0, 1, '0);
    rv_cnt  = 0;
    last_rv = -1;
    done_at = -1;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (bus.res_valid) begin
        rv_cnt++;
        last_rv = c;
      end
      if (bus.done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    check("max_done_seen",  0, 32'(done_at >= 0), 32'(1));
    check("max_rv_count",   0, 32'(rv_cnt), 32'(255));
    check("max_done_cycle", 0, 32'(done_at), 32'(262));
    check("max_last_rv",    0, 32'(last_rv), 32'(261));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
